wb_rr_arbiter: RTL and testbench
================================

Name: wb_rr_arbiter

Overview:
- Round-robin Wishbone arbiter that shares one slave port, such as the LED output register, between MASTERS requesters.
- Grants ownership for a whole bus cycle (cyc held) and muxes the owner's signals to the slave.
- Routes ack and data back to the owner only.
- A watchdog aborts cycles in which the slave never acks.

Parameters:
- WORD, 16, system word size; must be a multiple of 8.
- MASTERS, 2, number of requesting masters, 2..8.
- TIMEOUT, 15, max consecutive cycles with owner stb high and no s_ack_i before abort; must be ≥1.

Ports:
- clk_i  in  1  system clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- m_cyc_i  in  MASTERS  per-master cyc.
- m_stb_i  in  MASTERS  per-master stb.
- m_we_i  in  MASTERS  per-master we.
- m_sel_i  in  MASTERS*WORD/8  per-master sel; master k occupies bits [k*WORD/8 +: WORD/8].
- m_dat_i  in  MASTERS*WORD  per-master write data; master k occupies bits [k*WORD +: WORD].
- m_ack_o  out  MASTERS  ack, owner bit only.
- m_err_o  out  MASTERS  one-cycle abort pulse to the owner.
- m_dat_o  out  WORD  read data, broadcast to all masters (s_dat_i passthrough).
- s_cyc_o  out  1  slave cyc.
- s_stb_o  out  1  slave stb.
- s_we_o  out  1  slave we.
- s_sel_o  out  WORD/8  slave sel.
- s_dat_o  out  WORD  slave write data.
- s_ack_i  in  1  slave ack.
- s_dat_i  in  WORD  slave read data.
- gnt_o  out  MASTERS  registered one-hot grant.
- busy_o  out  1  high while in OWNED or ABORT.

Behaviour:
- States: IDLE, OWNED, ABORT.
- Registers:
  - owner index
  - gnt_o (one-hot)
  - priority pointer ptr (index that wins ties next)
  - watchdog counter wdt, width $clog2(TIMEOUT+1)
- Reset (rst_i low, async):
  - state=IDLE, gnt_o=0, ptr=0, wdt=0, m_err_o=0.
  - All s_* outputs and m_ack_o are 0 during reset and immediately after.
  - Reset mid-cycle drops s_cyc_o/s_stb_o combinationally via gnt_o=0.
- IDLE:
  - Requests are sampled from m_cyc_i.
  - If any bit is set, the winner is the first set index scanning ptr, ptr+1, … modulo MASTERS.
  - Next edge: state=OWNED, gnt_o=onehot(winner), owner=winner, wdt=0.
  - Latency: request in cycle n → slave sees cyc/stb in cycle n+1.
  - If no requests, state stays IDLE.
- OWNED, combinational mux:
  - s_cyc_o=m_cyc_i[owner]
  - s_stb_o=m_stb_i[owner]
  - s_we_o, s_sel_o and s_dat_o take the owner's slice.
  - m_ack_o[owner]=s_ack_i; other m_ack_o bits are 0.
  - Non-owner masters see no ack and wait.
- OWNED, watchdog:
  - If m_stb_i[owner] & ~s_ack_i, wdt increments.
  - Otherwise wdt clears to 0.
- OWNED, release:
  - When m_cyc_i[owner] is low, next edge gives state=IDLE, gnt_o=0, ptr=(owner+1) mod MASTERS.
  - No back-to-back grant: one IDLE cycle always separates ownerships.
- OWNED, timeout:
  - When wdt==TIMEOUT-1 and stb is still high with no ack, next edge gives state=ABORT, gnt_o=0, m_err_o[owner]=1 for exactly that one cycle, and wdt=0.
  - If s_ack_i and timeout coincide, ack wins: no abort, and wdt clears.
- ABORT:
  - s_cyc_o=s_stb_o=0; all m_ack_o=0.
  - Stays in ABORT until m_cyc_i[owner] is low, then goes to IDLE with ptr=(owner+1) mod MASTERS.
- Ownership stability: other masters' request changes never affect the current owner.
- Pointer wrap: from owner=MASTERS-1, ptr becomes 0.
- m_dat_o = s_dat_i at all times; masters qualify it with their own ack.

Test Plan:
- Reset: hold rst_i low with m_cyc_i=2'b11 → gnt_o=0, s_cyc_o=0, busy_o=0. Release reset, requests still high → gnt_o=2'b01 one edge later.
- Single write:
  - Stimulus: master 1 writes m_dat_i slice=16'hA5C3, sel=2'b11, we=1; slave acks combinationally (ack=cyc&stb); master drops cyc after ack.
  - Required: s_dat_o=16'hA5C3; m_ack_o=2'b10 in that cycle; gnt_o returns to 0 one edge after cyc drops.
- Round-robin fairness: both masters hold cyc continuously and drop it after each ack → grants alternate 01,10,01,10 with one IDLE cycle between each.
- Hold-off: master 0 owns and holds cyc for 5 cycles while master 1 requests → m_ack_o[1]=0 throughout; master 1 is granted the edge after master 0 releases.
- Timeout: TIMEOUT=4, slave never acks, master 0 holds stb → m_err_o=2'b01 for one cycle after 4 unacked cycles; s_cyc_o=0 until master 0 drops cyc; next grant goes to master 1 if it is requesting.
- Ack at timeout boundary: s_ack_i asserted exactly in the cycle where wdt==TIMEOUT-1 → no m_err_o, transfer completes normally.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: N masters share one slave port.
// A watchdog aborts any bus cycle in which the slave stops acking.
module wb_rr_arbiter #(
   parameter int WORD    = 16,
   parameter int MASTERS = 2,
   parameter int TIMEOUT = 15
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [MASTERS-1:0]        m_cyc_i,
   input  logic [MASTERS-1:0]        m_stb_i,
   input  logic [MASTERS-1:0]        m_we_i,
   input  logic [MASTERS*WORD/8-1:0] m_sel_i,
   input  logic [MASTERS*WORD-1:0]   m_dat_i,
   output logic [MASTERS-1:0]        m_ack_o,
   output logic [MASTERS-1:0]        m_err_o,
   output logic [WORD-1:0]           m_dat_o,
   output logic                      s_cyc_o,
   output logic                      s_stb_o,
   output logic                      s_we_o,
   output logic [WORD/8-1:0]         s_sel_o,
   output logic [WORD-1:0]           s_dat_o,
   input  logic                      s_ack_i,
   input  logic [WORD-1:0]           s_dat_i,
   output logic [MASTERS-1:0]        gnt_o,
   output logic                      busy_o
);

   localparam int AW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam int SW = WORD / 8;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_OWNED = 2'd1;
   localparam logic [1:0] S_ABORT = 2'd2;

   localparam logic [MASTERS-1:0] ONE = {{(MASTERS-1){1'b0}}, 1'b1};

   logic [1:0]         r_state;
   logic [AW-1:0]      r_owner;
   logic [AW-1:0]      r_ptr;
   logic [MASTERS-1:0] r_gnt;
   logic [MASTERS-1:0] r_err;
   logic [WW-1:0]      r_wdt;

   logic               w_found;
   logic [AW-1:0]      w_win;
   logic [AW:0]        w_idx;
   logic               w_cyc;
   logic               w_stb;
   logic               w_we;
   logic [SW-1:0]      w_sel;
   logic [WORD-1:0]    w_dat;
   logic               w_own;
   logic               w_stall;
   logic               w_wdt_hit;
   logic [AW-1:0]      w_nxt_ptr;
   logic [MASTERS-1:0] w_own_oh;
   logic [MASTERS-1:0] w_win_oh;

   // Scan ptr, ptr+1, ... modulo MASTERS; first requester wins.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = '0;
      for (int i = 0; i < MASTERS; i++) begin
         w_idx = {1'b0, r_ptr} + (AW+1)'(i);
         if (w_idx >= (AW+1)'(MASTERS))
            w_idx = w_idx - (AW+1)'(MASTERS);
         if (!w_found && m_cyc_i[w_idx[AW-1:0]]) begin
            w_found = 1'b1;
            w_win   = w_idx[AW-1:0];
         end
      end
   end

   always_comb begin
      w_cyc = 1'b0;
      w_stb = 1'b0;
      w_we  = 1'b0;
      w_sel = '0;
      w_dat = '0;
      for (int k = 0; k < MASTERS; k++) begin
         if (r_owner == AW'(k)) begin
            w_cyc = m_cyc_i[k];
            w_stb = m_stb_i[k];
            w_we  = m_we_i[k];
            w_sel = m_sel_i[k*SW +: SW];
            w_dat = m_dat_i[k*WORD +: WORD];
         end
      end
   end

   assign w_own     = |r_gnt;
   assign w_own_oh  = ONE << r_owner;
   assign w_win_oh  = ONE << w_win;
   assign w_stall   = w_stb & ~s_ack_i;
   assign w_wdt_hit = (r_wdt == WW'(TIMEOUT - 1));
   assign w_nxt_ptr = (r_owner == AW'(MASTERS - 1)) ?
                      '0 : r_owner + 1'b1;

   assign s_cyc_o = w_own & w_cyc;
   assign s_stb_o = w_own & w_stb;
   assign s_we_o  = w_own & w_we;
   assign s_sel_o = w_own ? w_sel : '0;
   assign s_dat_o = w_own ? w_dat : '0;
   assign m_ack_o = w_own ? (w_own_oh & {MASTERS{s_ack_i}}) : '0;
   assign m_err_o = r_err;
   assign m_dat_o = s_dat_i;
   assign gnt_o   = r_gnt;
   assign busy_o  = (r_state != S_IDLE);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= S_IDLE;
         r_owner <= '0;
         r_ptr   <= '0;
         r_gnt   <= '0;
         r_err   <= '0;
         r_wdt   <= '0;
      end else begin
         r_err <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_state <= S_OWNED;
                  r_owner <= w_win;
                  r_gnt   <= w_win_oh;
                  r_wdt   <= '0;
               end
            end
            S_OWNED: begin
               if (!w_cyc) begin
                  r_state <= S_IDLE;
                  r_gnt   <= '0;
                  r_ptr   <= w_nxt_ptr;
                  r_wdt   <= '0;
               end else if (w_stall && w_wdt_hit) begin
                  r_state <= S_ABORT;
                  r_gnt   <= '0;
                  r_err   <= w_own_oh;
                  r_wdt   <= '0;
               end else if (w_stall) begin
                  r_wdt <= r_wdt + 1'b1;
               end else begin
                  r_wdt <= '0;
               end
            end
            S_ABORT: begin
               if (!w_cyc) begin
                  r_state <= S_IDLE;
                  r_ptr   <= w_nxt_ptr;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_gnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter (2 masters, TIMEOUT=4).
// Slave write data is scoreboarded against the queued expectations.
module tb_wb_rr_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  m_cyc, m_stb, m_we;
   logic [3:0]  m_sel;
   logic [31:0] m_dat;
   logic [1:0]  m_ack, m_err;
   logic [15:0] m_dat_o;
   logic        s_cyc, s_stb, s_we;
   logic [1:0]  s_sel;
   logic [15:0] s_dat_o;
   logic        s_ack;
   logic [15:0] s_dat;
   logic [1:0]  gnt;
   logic        busy;
   logic        ack_en;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] sb[$];
   logic [15:0] exp_d;
   logic [1:0]  ack_prev;
   logic [1:0]  rr_exp [12];

   always #5 clk = ~clk;

   // Slave acks combinationally when enabled.
   assign s_ack = ack_en & s_cyc & s_stb;
   assign s_dat = 16'hBEEF;

   wb_rr_arbiter #(
      .WORD(16), .MASTERS(2), .TIMEOUT(4)
   ) dut (
      .clk_i(clk), .rst_i(rst_n),
      .m_cyc_i(m_cyc), .m_stb_i(m_stb),
      .m_we_i(m_we), .m_sel_i(m_sel),
      .m_dat_i(m_dat), .m_ack_o(m_ack),
      .m_err_o(m_err), .m_dat_o(m_dat_o),
      .s_cyc_o(s_cyc), .s_stb_o(s_stb),
      .s_we_o(s_we), .s_sel_o(s_sel),
      .s_dat_o(s_dat_o), .s_ack_i(s_ack),
      .s_dat_i(s_dat), .gnt_o(gnt),
      .busy_o(busy)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h want %0h",
                tag, obs, exp);
      end
   endtask

   task automatic nxt;
      @(posedge clk);
      #1;
   endtask

   task automatic smp;
      @(negedge clk);
   endtask

   // Scoreboard: every completed slave transfer pops one entry.
   always @(negedge clk) begin
      if (rst_n && s_cyc && s_stb && s_ack) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL sb_underflow: got %0h want none",
                   s_dat_o);
         end else begin
            exp_d = sb.pop_front();
            chk("s_dat_o", 32'(s_dat_o), 32'(exp_d));
         end
      end
   end

   initial begin
      rst_n  = 1'b0;
      m_cyc  = 2'b11;
      m_stb  = 2'b00;
      m_we   = 2'b00;
      m_sel  = 4'h0;
      m_dat  = 32'h0;
      ack_en = 1'b0;
      rr_exp = '{2'b00, 2'b01, 2'b01, 2'b00,
                 2'b10, 2'b10, 2'b00, 2'b01,
                 2'b01, 2'b00, 2'b10, 2'b10};

      // Reset
      nxt;
      smp;
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_scyc", 32'(s_cyc), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_ack", 32'(m_ack), 32'h0);
      chk("rst_err", 32'(m_err), 32'h0);
      chk("mdat_pass", 32'(m_dat_o), 32'hBEEF);
      nxt;
      rst_n = 1'b1;
      smp;
      chk("rel_gnt0", 32'(gnt), 32'h0);
      nxt;
      smp;
      chk("rel_gnt1", 32'(gnt), 32'h1);
      chk("rel_scyc", 32'(s_cyc), 32'h1);
      nxt;
      m_cyc = 2'b00;
      smp;
      chk("rel_drop", 32'(s_cyc), 32'h0);
      nxt;
      smp;
      chk("rel_idle", 32'(gnt), 32'h0);

      // Single write by master 1
      nxt;
      m_cyc  = 2'b10;
      m_stb  = 2'b10;
      m_we   = 2'b10;
      m_sel  = 4'b1100;
      m_dat  = {16'hA5C3, 16'h0000};
      ack_en = 1'b1;
      sb.push_back(16'hA5C3);
      smp;
      chk("wr_gnt0", 32'(gnt), 32'h0);
      nxt;
      smp;
      chk("wr_gnt", 32'(gnt), 32'h2);
      chk("wr_dat", 32'(s_dat_o), 32'hA5C3);
      chk("wr_ack", 32'(m_ack), 32'h2);
      chk("wr_sel", 32'(s_sel), 32'h3);
      chk("wr_we", 32'(s_we), 32'h1);
      nxt;
      m_cyc = 2'b00;
      m_stb = 2'b00;
      smp;
      chk("wr_hold", 32'(gnt), 32'h2);
      chk("wr_scyc", 32'(s_cyc), 32'h0);
      nxt;
      smp;
      chk("wr_rel", 32'(gnt), 32'h0);
      chk("wr_busy", 32'(busy), 32'h0);

      // Round-robin fairness
      m_we  = 2'b11;
      m_sel = 4'hF;
      m_dat = {16'h2222, 16'h1111};
      sb.push_back(16'h1111);
      sb.push_back(16'h2222);
      sb.push_back(16'h1111);
      sb.push_back(16'h2222);
      ack_prev = 2'b00;
      for (int i = 0; i < 12; i++) begin
         nxt;
         m_cyc = ~ack_prev;
         m_stb = ~ack_prev;
         smp;
         chk($sformatf("rr_gnt%0d", i),
             32'(gnt), 32'(rr_exp[i]));
         ack_prev = m_ack;
      end
      nxt;
      m_cyc = 2'b00;
      m_stb = 2'b00;
      smp;
      chk("rr_end", 32'(gnt), 32'h0);

      // Hold-off: master 0 owns, master 1 waits
      nxt;
      m_cyc  = 2'b11;
      m_stb  = 2'b11;
      m_dat  = {16'h4444, 16'h3333};
      ack_en = 1'b1;
      for (int i = 0; i < 5; i++)
         sb.push_back(16'h3333);
      sb.push_back(16'h4444);
      smp;
      chk("ho_idle", 32'(gnt), 32'h0);
      for (int i = 0; i < 5; i++) begin
         nxt;
         smp;
         chk($sformatf("ho_gnt%0d", i),
             32'(gnt), 32'h1);
         chk($sformatf("ho_ack%0d", i),
             32'(m_ack), 32'h1);
      end
      nxt;
      m_cyc = 2'b10;
      m_stb = 2'b10;
      smp;
      chk("ho_rel", 32'(gnt), 32'h1);
      chk("ho_ack_rel", 32'(m_ack), 32'h0);
      nxt;
      smp;
      chk("ho_gap", 32'(gnt), 32'h0);
      nxt;
      smp;
      chk("ho_gnt1", 32'(gnt), 32'h2);
      chk("ho_ack1", 32'(m_ack), 32'h2);
      nxt;
      m_cyc = 2'b00;
      m_stb = 2'b00;
      smp;
      nxt;
      smp;
      chk("ho_end", 32'(gnt), 32'h0);

      // Timeout on master 0
      nxt;
      m_cyc  = 2'b11;
      m_stb  = 2'b11;
      ack_en = 1'b0;
      smp;
      for (int i = 0; i < 4; i++) begin
         nxt;
         smp;
         chk($sformatf("to_gnt%0d", i),
             32'(gnt), 32'h1);
         chk($sformatf("to_err%0d", i),
             32'(m_err), 32'h0);
      end
      nxt;
      smp;
      chk("to_err", 32'(m_err), 32'h1);
      chk("to_scyc", 32'(s_cyc), 32'h0);
      chk("to_gnt", 32'(gnt), 32'h0);
      chk("to_busy", 32'(busy), 32'h1);
      nxt;
      smp;
      chk("to_err_clr", 32'(m_err), 32'h0);
      chk("to_scyc2", 32'(s_cyc), 32'h0);
      chk("to_busy2", 32'(busy), 32'h1);
      nxt;
      m_cyc = 2'b10;
      m_stb = 2'b10;
      smp;
      chk("to_abort", 32'(busy), 32'h1);
      nxt;
      smp;
      chk("to_idle", 32'(busy), 32'h0);
      nxt;
      smp;
      chk("to_next", 32'(gnt), 32'h2);
      nxt;
      m_cyc = 2'b00;
      m_stb = 2'b00;
      smp;
      nxt;
      smp;
      chk("to_end", 32'(gnt), 32'h0);

      // Ack exactly at the timeout boundary
      nxt;
      m_cyc = 2'b01;
      m_stb = 2'b01;
      m_dat = {16'h0000, 16'h5555};
      sb.push_back(16'h5555);
      smp;
      for (int i = 0; i < 3; i++) begin
         nxt;
         smp;
         chk($sformatf("bd_gnt%0d", i),
             32'(gnt), 32'h1);
      end
      nxt;
      ack_en = 1'b1;
      smp;
      chk("bd_ack", 32'(m_ack), 32'h1);
      nxt;
      m_cyc  = 2'b00;
      m_stb  = 2'b00;
      ack_en = 1'b0;
      smp;
      chk("bd_noerr", 32'(m_err), 32'h0);
      chk("bd_gnt", 32'(gnt), 32'h1);
      nxt;
      smp;
      chk("bd_noerr2", 32'(m_err), 32'h0);
      chk("bd_end", 32'(gnt), 32'h0);

      // Asynchronous reset in the middle of a cycle
      nxt;
      m_cyc = 2'b01;
      m_stb = 2'b01;
      nxt;
      smp;
      chk("mr_own", 32'(s_cyc), 32'h1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mr_scyc", 32'(s_cyc), 32'h0);
      chk("mr_sstb", 32'(s_stb), 32'h0);
      chk("mr_gnt", 32'(gnt), 32'h0);
      m_cyc = 2'b00;
      m_stb = 2'b00;
      #1;
      rst_n = 1'b1;
      nxt;

      chk("sb_left", 32'(sb.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed",
               n_tests, n_fail);
      $finish;
   end

endmodule
